// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_RUN  = 2'b10,
        S_FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: shift-add multiply (LSB-first) or
// restoring divide (MSB-first) on the {acc, shreg} pair.
module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] shreg_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        rem  = {acc, shreg[WIDTH-1]};
        diff = rem - {1'b0, operand};
        if (is_div) begin
            // A borrow out of the trial subtract means restore.
            if (diff[WIDTH]) begin
                acc_nxt   = rem[WIDTH-1:0];
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt   = diff[WIDTH-1:0];
                shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt   = sum[WIDTH:1];
            shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/DIV controller owning HI/LO, with PC stall on busy reads.
// Define MULT_DIV_SIGNED_EN to honour op_signed; otherwise all ops are unsigned.
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             read_hi,
    input  logic             read_lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] oper;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             b_zero;

`ifdef MULT_DIV_SIGNED_EN
    logic sgn;
    logic neg_q;
    logic neg_r;
    logic neg_a;
    logic neg_b;

    assign neg_a = sgn & a_reg[WIDTH-1];
    assign neg_b = sgn & b_reg[WIDTH-1];
`else
    logic unused_op_signed;

    assign unused_op_signed = op_signed;
`endif

    assign busy   = (state != S_IDLE);
    assign stall  = busy & (read_hi | read_lo | start);
    assign b_zero = (b_reg == '0);

    mult_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .shreg    (shreg),
        .operand  (oper),
        .acc_nxt  (acc_nxt),
        .shreg_nxt(shreg_nxt)
    );

    always_comb begin
        {res_hi, res_lo} = {acc, shreg};
`ifdef MULT_DIV_SIGNED_EN
        if (is_div) begin
            if (neg_q) res_lo = -shreg;
            if (neg_r) res_hi = -acc;
        end else if (neg_q) begin
            {res_hi, res_lo} = -{acc, shreg};
        end
`endif
        // Divide by zero returns a defined pattern instead of the raw iteration.
        if (is_div && b_zero) begin
            res_lo = '1;
            res_hi = a_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            shreg       <= '0;
            oper        <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
            sgn         <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        unique case (op_e'(op))
                            OP_MULT, OP_DIV: begin
                                is_div <= (op_e'(op) == OP_DIV);
                                a_reg  <= rs_data;
                                b_reg  <= rt_data;
`ifdef MULT_DIV_SIGNED_EN
                                sgn    <= op_signed;
`endif
                                state  <= S_PREP;
                            end
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                        endcase
                    end
                end
                S_PREP: begin
                    acc <= '0;
`ifdef MULT_DIV_SIGNED_EN
                    shreg <= neg_a ? -a_reg : a_reg;
                    oper  <= neg_b ? -b_reg : b_reg;
                    neg_q <= neg_a ^ neg_b;
                    neg_r <= neg_a;
`else
                    shreg <= a_reg;
                    oper  <= b_reg;
`endif
                    cnt   <= CNT_W'(WIDTH - 1);
                    state <= S_RUN;
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    shreg <= shreg_nxt;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (is_div && b_zero) div_by_zero <= 1'b1;
                end
            endcase
        end
    end

endmodule
